// File: rtl/ulpi_emu_pkg.sv
// Shared constants, FSM state type and USB CRC16 helper for the ULPI PHY emulator.
package ulpi_emu_pkg;

  localparam logic [3:0] PidIn    = 4'h9;
  localparam logic [3:0] PidAck   = 4'h2;
  localparam logic [3:0] PidNak   = 4'hA;
  localparam logic [3:0] PidData0 = 4'h3;
  localparam logic [3:0] PidData1 = 4'hB;

  localparam logic [7:0] RxCmdJ    = 8'h01;
  localparam logic [7:0] RxCmdDisc = 8'h20;
  localparam logic [7:0] RxCmdFill = 8'h10;
  localparam logic [7:0] RxCmdEop  = 8'h09;

  typedef enum logic [3:0] {
    StIdle, StTxWait, StTxData, StTaIn, StRxCmd, StFill,
    StRPid, StRData, StRCrc0, StRCrc1, StREop, StTaOut
  } state_e;

  typedef enum logic [1:0] {RspAck, RspIn, RspJ, RspDisc} rsp_e;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  // Reflected form of polynomial 0x8005, bits consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/ulpi_phy_emu_if.sv
// ULPI bus plus payload/token side-band of the PHY emulator; master = link/bench, slave = PHY.
interface ulpi_phy_emu_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  logic [7:0]                  link_data_i;
  logic                        stp_i;
  logic                        dir_o;
  logic                        nxt_o;
  logic [7:0]                  data_o;
  logic                        connect_i;
  logic                        disconnect_i;
  logic                        pl_wr_i;
  logic [7:0]                  pl_data_i;
  logic                        pl_full_o;
  logic [$clog2(FIFO_DEPTH):0] pl_level_o;
  logic                        tok_valid_o;
  logic [3:0]                  tok_pid_o;
  logic [7:0]                  tok_len_o;
  logic                        host_ack_o;
  logic                        ovf_o;

  modport master (
    output link_data_i, stp_i, connect_i, disconnect_i, pl_wr_i, pl_data_i,
    input  dir_o, nxt_o, data_o, pl_full_o, pl_level_o, tok_valid_o, tok_pid_o, tok_len_o,
           host_ack_o, ovf_o
  );

  modport slave (
    input  link_data_i, stp_i, connect_i, disconnect_i, pl_wr_i, pl_data_i,
    output dir_o, nxt_o, data_o, pl_full_o, pl_level_o, tok_valid_o, tok_pid_o, tok_len_o,
           host_ack_o, ovf_o
  );
endinterface

// File: rtl/ulpi_emu_fifo.sv
// 8-bit synchronous payload FIFO with occupancy output and sticky overflow flag.
module ulpi_emu_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  logic          ovf_q;
  logic          do_wr, do_rd;

  assign full    = (level_q == (AW + 1)'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && (level_q != '0);
  assign rd_data = mem[rptr_q];
  assign level   = level_q;
  assign ovf     = ovf_q;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      level_q <= level_q + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
      if (wr_en && full) ovf_q <= 1'b1;
    end
  end
endmodule

// File: rtl/ulpi_phy_emu.sv
// Device-side ULPI PHY emulator: TX CMD handshake, RX CMDs, auto-ACK and IN responses.
// Define ULPI_EMU_CRC16_EN to send the real payload CRC16 instead of FF FF.
module ulpi_phy_emu
  import ulpi_emu_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 5,
  parameter int unsigned FILL_CYCLES   = 0,
  parameter int unsigned NXT_DELAY     = 1,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter bit          AUTO_ACK      = 1'b1
) (
  input logic           usb_clk,
  input logic           rst,
  ulpi_phy_emu_if.slave ulpi
);
  state_e     state_q;
  rsp_e       rsp_q;
  logic [3:0] pid_q, tok_pid_q;
  logic [7:0] len_q, tok_len_q, cnt_q, data_q;
  logic       dir_q, nxt_q, tok_valid_q, host_ack_q;
  logic       rsp_pend_q, rsp_dly_q, short_q, toggle_q, in_sent_q;
  logic       conn_pend_q, disc_pend_q;

  logic [7:0]                  fifo_rdata, crc_lo, crc_hi;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        pop, fifo_short;
  logic [3:0]                  rsp_pid;
  logic                        unused_link;

  assign unused_link = ^ulpi.link_data_i[5:4];
  assign fifo_short  = 32'(fifo_level) < PAYLOAD_BYTES;

  always_comb begin
    rsp_pid = PidAck;
    if (rsp_q == RspIn) rsp_pid = fifo_short ? PidNak : (toggle_q ? PidData1 : PidData0);
  end

  // Each pop loads the byte that goes on the bus in the following cycle.
  always_comb begin
    pop = 1'b0;
    if (state_q == StRPid && !short_q) pop = 1'b1;
    if (state_q == StRData && cnt_q != 8'(PAYLOAD_BYTES - 1)) pop = 1'b1;
  end

  ulpi_emu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (usb_clk),
    .rst     (rst),
    .wr_en   (ulpi.pl_wr_i),
    .wr_data (ulpi.pl_data_i),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (ulpi.pl_full_o),
    .level   (fifo_level),
    .ovf     (ulpi.ovf_o)
  );

`ifdef ULPI_EMU_CRC16_EN
  logic [15:0] crc_q;
  always_ff @(posedge usb_clk) begin
    if (!rst)                   crc_q <= 16'hFFFF;
    else if (state_q == StTaIn) crc_q <= 16'hFFFF;
    else if (pop)               crc_q <= crc16_byte(crc_q, fifo_rdata);
  end
  assign crc_lo = ~crc_q[7:0];
  assign crc_hi = ~crc_q[15:8];
`else
  assign crc_lo = 8'hFF;
  assign crc_hi = 8'hFF;
`endif

  always_ff @(posedge usb_clk) begin
    if (!rst) begin
      state_q <= StIdle;   rsp_q      <= RspAck;
      pid_q   <= '0;       tok_pid_q  <= '0;    len_q       <= '0;   tok_len_q   <= '0;
      cnt_q   <= '0;       data_q     <= '0;    dir_q       <= 1'b0; nxt_q       <= 1'b0;
      tok_valid_q <= 1'b0; host_ack_q <= 1'b0;  rsp_pend_q  <= 1'b0; rsp_dly_q   <= 1'b0;
      short_q <= 1'b0;     toggle_q   <= 1'b0;  in_sent_q   <= 1'b0;
      conn_pend_q <= 1'b0; disc_pend_q <= 1'b0;
    end else begin
      tok_valid_q <= 1'b0;
      host_ack_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rsp_pend_q) begin
            if (rsp_dly_q) begin
              rsp_dly_q <= 1'b0;
            end else begin
              rsp_pend_q <= 1'b0;
              dir_q      <= 1'b1;
              data_q     <= '0;
              state_q    <= StTaIn;
            end
          end else if (ulpi.link_data_i[7:6] == 2'b01 && !dir_q) begin
            pid_q   <= ulpi.link_data_i[3:0];
            len_q   <= '0;
            cnt_q   <= '0;
            state_q <= StTxWait;
          end else if (conn_pend_q || disc_pend_q) begin
            if (conn_pend_q) conn_pend_q <= 1'b0;
            else             disc_pend_q <= 1'b0;
            rsp_q   <= conn_pend_q ? RspJ : RspDisc;
            dir_q   <= 1'b1;
            data_q  <= '0;
            state_q <= StTaIn;
          end
        end
        StTxWait: begin
          if (cnt_q == 8'(NXT_DELAY - 1)) begin
            nxt_q   <= 1'b1;
            state_q <= StTxData;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StTxData: begin
          if (ulpi.stp_i) begin
            nxt_q       <= 1'b0;
            tok_valid_q <= 1'b1;
            tok_pid_q   <= pid_q;
            tok_len_q   <= len_q;
            in_sent_q   <= 1'b0;
            state_q     <= StIdle;
            if (pid_q == PidIn) begin
              rsp_pend_q <= 1'b1;
              rsp_dly_q  <= 1'b1;
              rsp_q      <= RspIn;
            end else if ((pid_q == PidData0 || pid_q == PidData1) && AUTO_ACK) begin
              rsp_pend_q <= 1'b1;
              rsp_dly_q  <= 1'b1;
              rsp_q      <= RspAck;
            end else if (pid_q == PidAck && in_sent_q) begin
              host_ack_q <= 1'b1;
              toggle_q   <= ~toggle_q;
            end
          end else if (len_q != 8'hFF) begin
            len_q <= len_q + 8'd1;
          end
        end
        StTaIn: begin
          if (rsp_q == RspJ || rsp_q == RspDisc) begin
            data_q  <= (rsp_q == RspJ) ? RxCmdJ : RxCmdDisc;
            state_q <= StRxCmd;
          end else if (FILL_CYCLES != 0) begin
            data_q  <= RxCmdFill;
            cnt_q   <= '0;
            state_q <= StFill;
          end else begin
            data_q  <= pid_byte(rsp_pid);
            nxt_q   <= 1'b1;
            short_q <= (rsp_pid != PidData0) && (rsp_pid != PidData1);
            state_q <= StRPid;
          end
        end
        StRxCmd: begin
          data_q  <= '0;
          state_q <= StTaOut;
        end
        StFill: begin
          if (cnt_q == 8'(FILL_CYCLES - 1)) begin
            data_q  <= pid_byte(rsp_pid);
            nxt_q   <= 1'b1;
            short_q <= (rsp_pid != PidData0) && (rsp_pid != PidData1);
            state_q <= StRPid;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StRPid: begin
          if (short_q) begin
            data_q  <= RxCmdEop;
            nxt_q   <= 1'b0;
            state_q <= StREop;
          end else begin
            data_q  <= fifo_rdata;
            cnt_q   <= '0;
            state_q <= StRData;
          end
        end
        StRData: begin
          if (cnt_q == 8'(PAYLOAD_BYTES - 1)) begin
            data_q  <= crc_lo;
            state_q <= StRCrc0;
          end else begin
            data_q <= fifo_rdata;
            cnt_q  <= cnt_q + 8'd1;
          end
        end
        StRCrc0: begin
          data_q  <= crc_hi;
          state_q <= StRCrc1;
        end
        StRCrc1: begin
          data_q  <= RxCmdEop;
          nxt_q   <= 1'b0;
          state_q <= StREop;
        end
        StREop: begin
          data_q  <= '0;
          state_q <= StTaOut;
        end
        StTaOut: begin
          dir_q   <= 1'b0;
          data_q  <= '0;
          state_q <= StIdle;
          if (rsp_q == RspIn && !short_q) in_sent_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
      // Late assignment so a pulse coinciding with a take is not lost.
      if (ulpi.connect_i)    conn_pend_q <= 1'b1;
      if (ulpi.disconnect_i) disc_pend_q <= 1'b1;
    end
  end

  assign ulpi.dir_o       = dir_q;
  assign ulpi.nxt_o       = nxt_q;
  assign ulpi.data_o      = data_q;
  assign ulpi.pl_level_o  = fifo_level;
  assign ulpi.tok_valid_o = tok_valid_q;
  assign ulpi.tok_pid_o   = tok_pid_q;
  assign ulpi.tok_len_o   = tok_len_q;
  assign ulpi.host_ack_o  = host_ack_q;
endmodule

// File: tb/tb_ulpi_phy_emu.sv
// Scoreboard bench for ulpi_phy_emu: default instance plus a FILL_CYCLES=3 / NXT_DELAY=3 instance.
module tb_ulpi_phy_emu;
  typedef struct packed {logic [7:0] data; logic nxt;} bus_t;
  typedef struct packed {logic [3:0] pid; logic [7:0] len;} tok_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic [7:0] l_data = '0, l_wdata = '0;
  logic       l_stp = 1'b0, l_conn = 1'b0, l_disc = 1'b0, l_wr = 1'b0;

  ulpi_phy_emu_if #(.FIFO_DEPTH(16)) bus_a ();
  ulpi_phy_emu_if #(.FIFO_DEPTH(16)) bus_b ();

  ulpi_phy_emu dut_a (.usb_clk(clk), .rst(rst), .ulpi(bus_a));
  ulpi_phy_emu #(.FILL_CYCLES(3), .NXT_DELAY(3)) dut_b (.usb_clk(clk), .rst(rst), .ulpi(bus_b));

  assign bus_a.link_data_i  = sel ? 8'h00 : l_data;
  assign bus_a.stp_i        = sel ? 1'b0 : l_stp;
  assign bus_a.connect_i    = sel ? 1'b0 : l_conn;
  assign bus_a.disconnect_i = sel ? 1'b0 : l_disc;
  assign bus_a.pl_wr_i      = sel ? 1'b0 : l_wr;
  assign bus_a.pl_data_i    = l_wdata;
  assign bus_b.link_data_i  = sel ? l_data : 8'h00;
  assign bus_b.stp_i        = sel ? l_stp : 1'b0;
  assign bus_b.connect_i    = sel ? l_conn : 1'b0;
  assign bus_b.disconnect_i = sel ? l_disc : 1'b0;
  assign bus_b.pl_wr_i      = sel ? l_wr : 1'b0;
  assign bus_b.pl_data_i    = l_wdata;

  logic       o_dir, o_nxt, o_full, o_ovf, o_tokv, o_hack;
  logic [7:0] o_data, o_len;
  logic [3:0] o_pid;
  logic [4:0] o_level;
  assign o_dir   = sel ? bus_b.dir_o       : bus_a.dir_o;
  assign o_nxt   = sel ? bus_b.nxt_o       : bus_a.nxt_o;
  assign o_data  = sel ? bus_b.data_o      : bus_a.data_o;
  assign o_full  = sel ? bus_b.pl_full_o   : bus_a.pl_full_o;
  assign o_ovf   = sel ? bus_b.ovf_o       : bus_a.ovf_o;
  assign o_level = sel ? bus_b.pl_level_o  : bus_a.pl_level_o;
  assign o_tokv  = sel ? bus_b.tok_valid_o : bus_a.tok_valid_o;
  assign o_pid   = sel ? bus_b.tok_pid_o   : bus_a.tok_pid_o;
  assign o_len   = sel ? bus_b.tok_len_o   : bus_a.tok_len_o;
  assign o_hack  = sel ? bus_b.host_ack_o  : bus_a.host_ack_o;

  bus_t exp_bus[$];
  tok_t exp_tok[$];
  int   exp_hack = 0;
  int   n_cmp = 0, n_fail = 0;
  bit   rx_mon_off = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (o_dir && !rx_mon_off) begin
        if (exp_bus.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rx_unexpected: got dir=1 data=%0h, expected dir=0", o_data);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          check("rx_data", o_data, e.data);
          check("rx_nxt", o_nxt, e.nxt);
        end
      end
      if (o_tokv) begin
        if (exp_tok.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tok_unexpected: got pid=%0h, expected no token", o_pid);
        end else begin
          tok_t t;
          t = exp_tok.pop_front();
          check("tok_pid", o_pid, t.pid);
          check("tok_len", o_len, t.len);
        end
      end
      if (o_hack) begin
        n_cmp++;
        if (exp_hack == 0) begin
          n_fail++;
          $display("FAIL host_ack: got pulse, expected none");
        end else exp_hack--;
      end
    end
  end

  function automatic logic [15:0] tb_crc(input logic [7:0] first, input int n);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic n);
    exp_bus.push_back('{data: d, nxt: n});
  endtask

  task automatic exp_rxcmd(input logic [7:0] cmd);
    push(8'h00, 1'b0); push(cmd, 1'b0); push(8'h00, 1'b0);
  endtask

  task automatic exp_resp(input logic [7:0] pid, input int fill, input int n, input logic [7:0] first);
    logic [15:0] crc;
`ifdef ULPI_EMU_CRC16_EN
    crc = tb_crc(first, n);
`else
    crc = 16'hFFFF;
`endif
    push(8'h00, 1'b0);
    for (int i = 0; i < fill; i++) push(8'h10, 1'b0);
    push(pid, 1'b1);
    for (int i = 0; i < n; i++) push(first + 8'(i), 1'b1);
    if (n > 0) begin
      push(crc[7:0], 1'b1); push(crc[15:8], 1'b1);
    end
    push(8'h09, 1'b0); push(8'h00, 1'b0);
  endtask

  task automatic send_pkt(input logic [7:0] txcmd, input int nbytes, input int dly);
    int k;
    k = 0;
    l_data = txcmd;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      cyc(1);
      if (o_nxt) k = i;
    end
    check("nxt_latency", k, dly + 1);
    for (int i = 0; i < nbytes; i++) begin
      cyc(1);
      l_data = 8'hA0 + 8'(i);
    end
    cyc(1);
    l_data = 8'h00; l_stp = 1'b1;
    cyc(1);
    l_stp = 1'b0;
    check("nxt_after_stp", o_nxt, 0);
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      l_wr = 1'b1; l_wdata = first + 8'(i);
      cyc(1);
    end
    l_wr = 1'b0;
  endtask

  task automatic wait_dir;
    for (int i = 0; i < 20 && !o_dir; i++) cyc(1);
    check("dir_seen", o_dir, 1);
  endtask

  initial begin
    cyc(3);
    check("rst_dir", o_dir, 0);
    check("rst_nxt", o_nxt, 0);
    check("rst_data", o_data, 0);
    check("rst_ovf", o_ovf, 0);
    check("rst_level", o_level, 0);
    check("rst_tokv", o_tokv, 0);
    rst = 1'b1;
    cyc(1);

    exp_rxcmd(8'h01);
    l_conn = 1'b1; cyc(1); l_conn = 1'b0;
    cyc(10);

    exp_tok.push_back('{pid: 4'hD, len: 8'd3});
    send_pkt(8'h4D, 2, 1); cyc(20);
    exp_tok.push_back('{pid: 4'h3, len: 8'd9});
    exp_resp(8'hD2, 0, 0, 8'h00);
    send_pkt(8'h43, 8, 1); cyc(20);

    exp_tok.push_back('{pid: 4'h9, len: 8'd1});
    exp_resp(8'h5A, 0, 0, 8'h00);
    send_pkt(8'h49, 0, 1); cyc(20);
    check("nak_level", o_level, 0);

    load(8'h11, 5);
    check("load_level", o_level, 5);
    exp_tok.push_back('{pid: 4'h9, len: 8'd1});
    exp_resp(8'hC3, 0, 5, 8'h11);
    send_pkt(8'h49, 0, 1); cyc(25);
    check("drain_level", o_level, 0);

    exp_tok.push_back('{pid: 4'h2, len: 8'd1});
    exp_hack++;
    send_pkt(8'h42, 0, 1); cyc(10);
    load(8'h21, 5);
    exp_tok.push_back('{pid: 4'h9, len: 8'd1});
    exp_resp(8'h4B, 0, 5, 8'h21);
    send_pkt(8'h49, 0, 1); cyc(25);

    load(8'h40, 17);
    check("ovf_level", o_level, 16);
    check("ovf_full", o_full, 1);
    check("ovf_flag", o_ovf, 1);

    sel = 1'b1;
    cyc(1);
    load(8'h31, 5);
    exp_tok.push_back('{pid: 4'h9, len: 8'd1});
    exp_resp(8'hC3, 3, 5, 8'h31);
    exp_rxcmd(8'h20);
    send_pkt(8'h49, 0, 3);
    wait_dir();
    cyc(2);
    l_disc = 1'b1; cyc(1); l_disc = 1'b0;
    cyc(40);

    sel = 1'b0;
    cyc(1);
    rx_mon_off = 1'b1;
    exp_tok.push_back('{pid: 4'h9, len: 8'd1});
    send_pkt(8'h49, 0, 1);
    wait_dir();
    cyc(2);
    check("mid_data_nxt", o_nxt, 1);
    rst = 1'b0;
    cyc(1);
    check("mid_rst_dir", o_dir, 0);
    check("mid_rst_nxt", o_nxt, 0);
    check("mid_rst_level", o_level, 0);
    check("mid_rst_ovf", o_ovf, 0);
    rst = 1'b1;
    cyc(3);

    check("rx_left", exp_bus.size(), 0);
    check("tok_left", exp_tok.size(), 0);
    check("hack_left", exp_hack, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ulpi_phy_emu.md
Name: ulpi_phy_emu

Overview:
- Synthesizable, parametrised ULPI PHY emulator (device side) that takes the place of hand-written PHY tasks in benches and FPGA loopback builds for usb_cdc.
- Answers link TX CMDs with nxt/stp handshakes and drives connect/disconnect RX CMDs.
- Auto-ACKs host DATA packets.
- Answers IN tokens with DATA0/DATA1 interrupt packets from an internal payload FIFO, or with NAK when no payload is ready.
- Packet length, RX CMD filler count, nxt latency and FIFO depth are configurable.

Parameters:
- PAYLOAD_BYTES, 5, data bytes per IN response (1..64).
- FILL_CYCLES, 0, RX CMD filler cycles (0x10, nxt=0) inserted before the response PID.
- NXT_DELAY, 1, cycles from TX CMD detection to nxt assertion (1..4).
- FIFO_DEPTH, 16, payload FIFO entries (power of two, >= PAYLOAD_BYTES).
- AUTO_ACK, 1, send a device ACK after each host DATA0/DATA1 packet.

Ports:
- usb_clk  in  1  ULPI 60 MHz clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- link_data_i  in  8  link-driven ULPI data (link data_o).
- stp_i  in  1  link stp.
- dir_o  out  1  ULPI dir.
- nxt_o  out  1  ULPI nxt.
- data_o  out  8  PHY-driven ULPI data (link data_i); valid while dir_o=1.
- connect_i  in  1  pulse: emit J line-state RX CMD.
- disconnect_i  in  1  pulse: emit disconnect RX CMD.
- pl_wr_i  in  1  payload FIFO write strobe.
- pl_data_i  in  8  payload byte.
- pl_full_o  out  1  FIFO full.
- pl_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- tok_valid_o  out  1  1-cycle pulse when a link packet completes (stp sampled).
- tok_pid_o  out  4  PID of that packet.
- tok_len_o  out  8  bytes transferred while nxt=1, TX CMD included.
- host_ack_o  out  1  pulse when the host ACKs an IN data packet.
- ovf_o  out  1  sticky: write attempted while full.

Behaviour:
- Reset (rst=0 at the edge):
  - dir_o=0, nxt_o=0, data_o=8'h00, all pulses 0, ovf_o=0.
  - FIFO emptied; data toggle set to DATA0; FSM to IDLE.
  - Applies mid-transfer with no completion pulse.
- FSM states: IDLE, TX_WAIT, TX_DATA, TA_IN, RXCMD, FILL, R_PID, R_DATA, R_CRC0, R_CRC1, R_EOP, TA_OUT.
- IDLE:
  - link_data_i[7:6]==2'b01 with dir_o=0 -> latch PID=link_data_i[3:0], go to TX_WAIT.
  - else a pending connect/disconnect -> TA_IN; connect has priority.
  - Connect/disconnect pulses arriving while not IDLE are held in one pending bit each.
- TX_WAIT: count NXT_DELAY cycles, then nxt_o=1, go to TX_DATA.
- TX_DATA:
  - Count one byte per cycle with nxt_o=1.
  - On stp_i=1: nxt_o=0 on the next edge, pulse tok_valid_o, go to IDLE.
  - PID 4'h9 (IN): schedule an IN response 2 cycles later.
  - PID 4'h3/4'hB with AUTO_ACK=1: schedule an ACK 2 cycles later.
  - PID 4'h2 (ACK) arriving after an IN response: pulse host_ack_o, flip the data toggle.
- Response sequence:
  - TA_IN: dir_o=1, nxt_o=0, 1 turnaround cycle.
  - RXCMD: connect sends data_o=8'h01; disconnect sends 8'h20; then TA_OUT.
  - FILL: FILL_CYCLES cycles of 8'h10 with nxt_o=0.
  - R_PID: nxt_o=1, data_o={~PID,PID}.
    - ACK sends 8'hD2.
    - NAK sends 8'h5A, used when pl_level_o < PAYLOAD_BYTES.
    - DATA0 sends 8'hC3; DATA1 sends 8'h4B.
  - R_DATA: PAYLOAD_BYTES FIFO pops, one per cycle.
  - R_CRC0/R_CRC1: 8'hFF, 8'hFF.
  - R_EOP: data_o=8'h09, nxt_o=0.
  - TA_OUT: dir_o=0, data_o=8'h00, return to IDLE.
  - ACK/NAK skip R_DATA and the CRC states.
- FIFO:
  - Write while full is dropped and sets ovf_o.
  - Simultaneous write and pop in the same cycle are both honoured.
  - Pointers wrap modulo FIFO_DEPTH.
- stp_i while dir_o=1 is ignored.
- tok_len_o saturates at 255.

Optional Feature:
- Macro ULPI_EMU_CRC16_EN.
- Defined: R_CRC0/R_CRC1 carry the true USB CRC16 of the payload, sent low byte first. The CRC16 is polynomial 0x8005, init 0xFFFF, final inversion, LSB-first bit order.
- Undefined: constant 8'hFF, 8'hFF.

Decomposition:
- ulpi_emu_pkg holds:
  - PID constants, RX CMD constants (J=8'h01, DISC=8'h20, FILL=8'h10, EOP=8'h09).
  - State enum and the CRC16 function.
- One sub-module: ulpi_emu_fifo, a synchronous FIFO with level output, parametrised depth, width 8.

Test Plan:
- Connect: connect_i pulse -> dir_o=1 for 3 cycles, data_o=8'h01 in the middle cycle, then dir_o=0.
- SETUP: link sends TX CMD 8'h4D plus 2 bytes, stp -> nxt_o rises NXT_DELAY cycles later; tok_pid_o=4'hD, tok_len_o=3. A following DATA0 packet (8'h43 plus 8 bytes) -> device ACK data_o=8'hD2 with nxt_o=1.
- IN with FIFO empty: TX CMD 8'h49 -> NAK 8'h5A, no pops, toggle unchanged.
- IN with 5 bytes 11..15 loaded: 8'hC3, 11, 12, 13, 14, 15, FF, FF, then 09 with nxt_o=0. Host ACK -> host_ack_o pulses; the next IN returns 8'h4B.
- FILL_CYCLES=3: three 8'h10 cycles with nxt_o=0 precede the PID; disconnect_i during the response is held, and 8'h20 is sent after return to IDLE.
- FIFO_DEPTH+1 writes -> pl_full_o=1, ovf_o=1. rst=0 mid-R_DATA -> dir_o=0, nxt_o=0, pl_level_o=0 on the next edge.
